// File: rtl/clk_rst_sequencer_pkg.sv
// Shared types and 27 MHz default timing for the board clock/reset sequencer.
// The output decode lives here so every consumer sees the same per-state reset levels.
package clk_rst_sequencer_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        DIV_SETTLE,
        RUN,
        FAIL
    } clk_seq_state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES      = 27;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2700;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 270000;
    localparam int unsigned DEF_DIV_SETTLE_CYCLES   = 16;
    localparam int unsigned DEF_MAX_RETRIES         = 3;
    localparam int unsigned DEF_SYNC_STAGES         = 2;

    typedef struct packed {
        logic pll_rst;
        logic clkdiv_rstn;
        logic sys_rst;
        logic ready;
        logic fail;
    } seq_out_t;

    function automatic seq_out_t state_outputs(input clk_seq_state_t s);
        seq_out_t o;
        o = '{pll_rst: 1'b0, clkdiv_rstn: 1'b0, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
        case (s)
            PLL_RST:    o.pll_rst = 1'b1;
            DIV_SETTLE: o.clkdiv_rstn = 1'b1;
            RUN: begin
                o.clkdiv_rstn = 1'b1;
                o.sys_rst     = 1'b0;
                o.ready       = 1'b1;
            end
            FAIL:       o.fail = 1'b1;
            default:    ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// Lock/restart inputs and reset/status outputs of the clock sequencer.
// master is the sequencer side; slave is the board/testbench side.
interface clk_rst_sequencer_if #(
    parameter int RETRY_W = 2
) ();
    logic               pll_lock_i;
    logic               restart_i;
    logic               pll_rst_o;
    logic               clkdiv_rstn_o;
    logic               sys_rst_o;
    logic               ready_o;
    logic               fail_o;
    logic [RETRY_W-1:0] retry_cnt_o;
    logic [7:0]         lock_loss_cnt_o;

    modport master (
        input  pll_lock_i, restart_i,
        output pll_rst_o, clkdiv_rstn_o, sys_rst_o, ready_o, fail_o,
        output retry_cnt_o, lock_loss_cnt_o
    );

    modport slave (
        output pll_lock_i, restart_i,
        input  pll_rst_o, clkdiv_rstn_o, sys_rst_o, ready_o, fail_o,
        input  retry_cnt_o, lock_loss_cnt_o
    );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level (PLL lock, key inputs).
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL -> clock divider -> core reset sequencer with lock qualification, timeout retries,
// lock-loss recovery and user restart. Outputs are registered decodes of the current state.
module clk_rst_sequencer
    import clk_rst_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int DIV_SETTLE_CYCLES   = DEF_DIV_SETTLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    clk_rst_sequencer_if.master bus
);
    localparam int CYC_MAX  = (LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES) ?
                              ((LOCK_TIMEOUT_CYCLES > DIV_SETTLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : DIV_SETTLE_CYCLES) :
                              ((PLL_RST_CYCLES > DIV_SETTLE_CYCLES) ? PLL_RST_CYCLES : DIV_SETTLE_CYCLES);
    localparam int CYC_W    = $clog2(CYC_MAX) + 1;
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

    clk_seq_state_t      state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [7:0]          loss_q, loss_d;
    seq_out_t            out_q, out_d;
    logic                lock_s;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (bus.pll_lock_i),
        .q_o     (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stable_d = '0;
        retry_d  = retry_q;
        loss_d   = loss_q;
        case (state_q)
            PLL_RST: begin
                if (cyc_q == CYC_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
                else                                     cyc_d   = cyc_q + CYC_W'(1);
            end
            WAIT_LOCK: begin
                cyc_d    = cyc_q + CYC_W'(1);
                stable_d = lock_s ? stable_q + STABLE_W'(1) : '0;
                // A qualified lock beats a timeout landing on the same cycle.
                if (lock_s && stable_q == STABLE_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = DIV_SETTLE;
                end else if (cyc_q == CYC_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = PLL_RST;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            DIV_SETTLE, RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (state_q == DIV_SETTLE) begin
                    if (cyc_q == CYC_W'(DIV_SETTLE_CYCLES - 1)) state_d = RUN;
                    else                                        cyc_d   = cyc_q + CYC_W'(1);
                end
            end
            default: ;
        endcase

        // Restart overrides everything except reset, but keeps the lock-loss history.
        if (bus.restart_i) begin
            state_d = PLL_RST;
            retry_d = '0;
            loss_d  = loss_q;
        end
        if (bus.restart_i || state_d != state_q) begin
            cyc_d    = '0;
            stable_d = '0;
        end

        out_d = state_outputs(state_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= PLL_RST;
            cyc_q    <= '0;
            stable_q <= '0;
            retry_q  <= '0;
            loss_q   <= '0;
            out_q    <= state_outputs(PLL_RST);
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            out_q    <= out_d;
        end
    end

    assign bus.pll_rst_o       = out_q.pll_rst;
    assign bus.clkdiv_rstn_o   = out_q.clkdiv_rstn;
    assign bus.sys_rst_o       = out_q.sys_rst;
    assign bus.ready_o         = out_q.ready;
    assign bus.fail_o          = out_q.fail;
    assign bus.retry_cnt_o     = retry_q;
    assign bus.lock_loss_cnt_o = loss_q;
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with shortened timing constants.
module tb_clk_rst_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    clk_rst_sequencer_if #(.RETRY_W(2)) bus ();

    clk_rst_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (50),
        .DIV_SETTLE_CYCLES   (4),
        .MAX_RETRIES         (2),
        .SYNC_STAGES         (2)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"},  32'(bus.pll_rst_o),       32'd1);
        chk({tag, "_clkdiv"},   32'(bus.clkdiv_rstn_o),   32'd0);
        chk({tag, "_sys_rst"},  32'(bus.sys_rst_o),       32'd1);
        chk({tag, "_ready"},    32'(bus.ready_o),         32'd0);
        chk({tag, "_fail"},     32'(bus.fail_o),          32'd0);
        chk({tag, "_retry"},    32'(bus.retry_cnt_o),     32'd0);
        chk({tag, "_loss"},     32'(bus.lock_loss_cnt_o), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.pll_lock_i = 1'b0;
        bus.restart_i  = 1'b0;
        tick(2);
        chk_reset_vals("por");
        rst_n = 1'b1;

        // Clean power-up: lock present from the first WAIT_LOCK cycle
        tick(4);  chk("t1_pll_hi",  32'(bus.pll_rst_o), 32'd1);
        bus.pll_lock_i = 1'b1;
        tick(1);  chk("t1_pll_lo",  32'(bus.pll_rst_o), 32'd0);
        tick(9);  chk("t1_div_pre", 32'(bus.clkdiv_rstn_o), 32'd0);
        tick(1);  chk("t1_div_rel", 32'(bus.clkdiv_rstn_o), 32'd1);
        tick(3);  chk("t1_rdy_pre", 32'(bus.ready_o), 32'd0);
        tick(1);  chk("t1_rdy",     32'(bus.ready_o), 32'd1);
        chk("t1_sys_rel", 32'(bus.sys_rst_o), 32'd0);

        // Lock loss in RUN
        bus.pll_lock_i = 1'b0;
        tick(3);  chk("t4_rdy_hold", 32'(bus.ready_o), 32'd1);
        tick(1);  chk("t4_sys_rst",  32'(bus.sys_rst_o), 32'd1);
        chk("t4_ready", 32'(bus.ready_o), 32'd0);
        chk("t4_loss",  32'(bus.lock_loss_cnt_o), 32'd1);
        chk("t4_retry", 32'(bus.retry_cnt_o), 32'd0);
        chk("t4_pll",   32'(bus.pll_rst_o), 32'd1);

        // One-cycle lock glitch partway through qualification
        tick(3);
        bus.pll_lock_i = 1'b1;
        tick(6);
        bus.pll_lock_i = 1'b0;
        tick(1);
        bus.pll_lock_i = 1'b1;
        tick(8);  chk("t2_rdy_nominal", 32'(bus.ready_o), 32'd0);
        tick(2);  chk("t2_div_pre",     32'(bus.clkdiv_rstn_o), 32'd0);
        tick(1);  chk("t2_div_rel",     32'(bus.clkdiv_rstn_o), 32'd1);
        tick(3);  chk("t2_rdy_pre",     32'(bus.ready_o), 32'd0);
        tick(1);  chk("t2_rdy",         32'(bus.ready_o), 32'd1);

        // Restart from RUN keeps lock-loss count
        bus.restart_i = 1'b1;
        tick(1);
        bus.restart_i = 1'b0;
        tick(1);  chk("t5r_pll_hi", 32'(bus.pll_rst_o), 32'd1);
        chk("t5r_rdy",  32'(bus.ready_o), 32'd0);
        chk("t5r_loss", 32'(bus.lock_loss_cnt_o), 32'd1);
        tick(3);  chk("t5r_pll_hi4", 32'(bus.pll_rst_o), 32'd1);
        tick(1);  chk("t5r_pll_lo",  32'(bus.pll_rst_o), 32'd0);
        tick(11); chk("t5r_rdy_pre", 32'(bus.ready_o), 32'd0);
        tick(1);  chk("t5r_rdy",     32'(bus.ready_o), 32'd1);
        chk("t5r_loss_keep", 32'(bus.lock_loss_cnt_o), 32'd1);

        // No lock: two retries then FAIL
        bus.restart_i  = 1'b1;
        bus.pll_lock_i = 1'b0;
        tick(1);
        bus.restart_i  = 1'b0;
        tick(53); chk("t3_retry0",  32'(bus.retry_cnt_o), 32'd0);
        tick(1);  chk("t3_retry1",  32'(bus.retry_cnt_o), 32'd1);
        tick(1);  chk("t3_pulse1",  32'(bus.pll_rst_o), 32'd1);
        tick(52); chk("t3_retry1h", 32'(bus.retry_cnt_o), 32'd1);
        tick(1);  chk("t3_retry2",  32'(bus.retry_cnt_o), 32'd2);
        tick(1);  chk("t3_pulse2",  32'(bus.pll_rst_o), 32'd1);
        tick(53); chk("t3_fail_pre", 32'(bus.fail_o), 32'd0);
        tick(1);  chk("t3_fail",    32'(bus.fail_o), 32'd1);
        chk("t3_sys",   32'(bus.sys_rst_o), 32'd1);
        chk("t3_pll",   32'(bus.pll_rst_o), 32'd0);
        chk("t3_div",   32'(bus.clkdiv_rstn_o), 32'd0);
        chk("t3_retry", 32'(bus.retry_cnt_o), 32'd2);
        tick(10); chk("t3_fail_hold", 32'(bus.fail_o), 32'd1);
        chk("t3_pll_hold", 32'(bus.pll_rst_o), 32'd0);

        // Restart out of FAIL
        bus.restart_i  = 1'b1;
        bus.pll_lock_i = 1'b1;
        tick(1);
        bus.restart_i  = 1'b0;
        chk("t5f_retry", 32'(bus.retry_cnt_o), 32'd0);
        tick(1);  chk("t5f_fail", 32'(bus.fail_o), 32'd0);
        chk("t5f_pll_hi", 32'(bus.pll_rst_o), 32'd1);
        tick(3);  chk("t5f_pll_hi4", 32'(bus.pll_rst_o), 32'd1);
        tick(1);  chk("t5f_pll_lo",  32'(bus.pll_rst_o), 32'd0);
        tick(11); chk("t5f_rdy_pre", 32'(bus.ready_o), 32'd0);
        tick(1);  chk("t5f_rdy",     32'(bus.ready_o), 32'd1);
        chk("t5f_loss", 32'(bus.lock_loss_cnt_o), 32'd1);

        // Build lock_loss_cnt to 3 (RUN loss, then DIV_SETTLE loss), then reset in DIV_SETTLE
        bus.pll_lock_i = 1'b0;
        tick(3);  chk("t6_loss2", 32'(bus.lock_loss_cnt_o), 32'd2);
        bus.pll_lock_i = 1'b1;
        tick(12);
        bus.pll_lock_i = 1'b0;
        tick(1);  chk("t6_in_settle", 32'(bus.clkdiv_rstn_o), 32'd1);
        tick(2);  chk("t6_loss3", 32'(bus.lock_loss_cnt_o), 32'd3);
        bus.pll_lock_i = 1'b1;
        tick(13); chk("t6_div_again", 32'(bus.clkdiv_rstn_o), 32'd1);
        chk("t6_loss3_keep", 32'(bus.lock_loss_cnt_o), 32'd3);
        rst_n = 1'b0;
        bus.pll_lock_i = 1'b0;
        tick(1);
        chk_reset_vals("t6_rst");
        rst_n = 1'b1;

        // Restart coincident with a lock timeout
        tick(53); chk("t6b_retry_pre", 32'(bus.retry_cnt_o), 32'd0);
        bus.restart_i = 1'b1;
        tick(1);
        bus.restart_i = 1'b0;
        chk("t6b_retry", 32'(bus.retry_cnt_o), 32'd0);
        tick(1);  chk("t6b_pll", 32'(bus.pll_rst_o), 32'd1);
        tick(53); chk("t6b_retry_next", 32'(bus.retry_cnt_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
